// File: rtl/cpu_pkg.sv
// Shared definitions for the MEM stage: FSM encoding, MEM/WB field widths and
// the default memory timeout.
package cpu_pkg;
  localparam int DATA_W          = 32;
  localparam int RADDR_W         = 5;
  localparam int DEFAULT_TIMEOUT = 255;

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} mem_state_e;

  typedef struct packed {
    logic               MemtoReg;
    logic               RegWrite;
    logic [RADDR_W-1:0] RegWriteAddr;
    logic [DATA_W-1:0]  ALUResult;
  } wb_ctl_t;
endpackage

// File: rtl/cpu_module_mem_stage_if.sv
// Data-memory req/ack port; the MEM stage is master, the memory is slave.
interface cpu_module_mem_stage_if;
  logic                      dmem_req;
  logic                      dmem_we;
  logic [cpu_pkg::DATA_W-1:0] dmem_addr;
  logic [cpu_pkg::DATA_W-1:0] dmem_wdata;
  logic [cpu_pkg::DATA_W-1:0] dmem_rdata;
  logic                      dmem_ack;

  modport master (output dmem_req, dmem_we, dmem_addr, dmem_wdata,
                  input  dmem_rdata, dmem_ack);
  modport slave  (input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
                  output dmem_rdata, dmem_ack);
endinterface

// File: rtl/cpu_module_mem_wb_reg.sv
// MEM/WB pipeline register. A bubble clears the writeback controls and holds
// the data fields; load data is only captured when ld_rdata_i is set.
module cpu_module_mem_wb_reg
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              bubble_i,
  input  logic              ld_rdata_i,
  input  wb_ctl_t           ctl_i,
  input  logic [DATA_W-1:0] rdata_i,
  output wb_ctl_t           ctl_o,
  output logic [DATA_W-1:0] rdata_o
);
  wb_ctl_t           ctl_q;
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctl_q   <= '0;
      rdata_q <= '0;
    end else if (bubble_i) begin
      ctl_q.MemtoReg <= 1'b0;
      ctl_q.RegWrite <= 1'b0;
    end else if (en_i) begin
      ctl_q <= ctl_i;
      if (ld_rdata_i) rdata_q <= rdata_i;
    end
  end

  assign ctl_o   = ctl_q;
  assign rdata_o = rdata_q;
endmodule

// File: rtl/cpu_module_mem_stage.sv
// Pipeline MEM stage: drives the data-memory handshake, stalls upstream while
// an access is outstanding, and flags misaligned accesses and bus timeouts.
module cpu_module_mem_stage
  import cpu_pkg::*;
#(
  parameter logic [7:0] TIMEOUT_CYCLES = 8'(DEFAULT_TIMEOUT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               MemtoReg_mem,
  input  logic               RegWrite_mem,
  input  logic               MemWrite_mem,
  input  logic               MemRead_mem,
  input  logic [DATA_W-1:0]  ALUResult_mem,
  input  logic [RADDR_W-1:0] RegWriteAddr_mem,
  input  logic [DATA_W-1:0]  MemWriteData_mem,
  cpu_module_mem_stage_if.master dmem,
  output logic               stall_mem,
  output logic               MemtoReg_wb,
  output logic               RegWrite_wb,
  output logic [RADDR_W-1:0] RegWriteAddr_wb,
  output logic [DATA_W-1:0]  ALUResult_wb,
  output logic [DATA_W-1:0]  MemReadData_wb,
  output logic               misalign_err,
  output logic               bus_err
);
  mem_state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       memop, aligned, timeout, req, req_g, ack, stall, squash;
  logic       misalign_d, misalign_q, bus_err_d, bus_err_q;
  wb_ctl_t    wb_d, wb_q;

  assign memop   = MemRead_mem | MemWrite_mem;
  assign aligned = (ALUResult_mem[1:0] == 2'b00);
  assign timeout = (state_q == WAIT) && (cnt_q == TIMEOUT_CYCLES - 8'd1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req     = 1'b0;
    case (state_q)
      IDLE: if (memop && aligned) begin
        req = 1'b1;
        if (!dmem.dmem_ack) begin
          state_d = WAIT;
          cnt_d   = 8'd0;
        end
      end
      WAIT: begin
        req = 1'b1;
        if (dmem.dmem_ack || timeout) state_d = IDLE;
        else                          cnt_d   = cnt_q + 8'd1;
      end
    endcase
  end

  // Reset gates the request combinationally so a held reset drops it at once.
  assign req_g  = rst & req;
  assign ack    = req_g & dmem.dmem_ack;
  assign stall  = req_g & ~dmem.dmem_ack & ~timeout;
  assign misalign_d = (state_q == IDLE) & memop & ~aligned;
  assign bus_err_d  = timeout & ~dmem.dmem_ack;
  assign squash     = misalign_d | bus_err_d;

  assign dmem.dmem_req   = req_g;
  assign dmem.dmem_we    = req_g & MemWrite_mem;
  assign dmem.dmem_addr  = req_g ? ALUResult_mem    : '0;
  assign dmem.dmem_wdata = req_g ? MemWriteData_mem : '0;
  assign stall_mem       = stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      misalign_q <= misalign_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign wb_d.MemtoReg     = MemtoReg_mem;
  assign wb_d.RegWrite     = RegWrite_mem & ~squash;
  assign wb_d.RegWriteAddr = RegWriteAddr_mem;
  assign wb_d.ALUResult    = ALUResult_mem;

  cpu_module_mem_wb_reg u_wb (
    .clk        (clk),
    .rst        (rst),
    .en_i       (~stall),
    .bubble_i   (stall),
    .ld_rdata_i (ack & ~MemWrite_mem),
    .ctl_i      (wb_d),
    .rdata_i    (dmem.dmem_rdata),
    .ctl_o      (wb_q),
    .rdata_o    (MemReadData_wb)
  );

  assign MemtoReg_wb     = wb_q.MemtoReg;
  assign RegWrite_wb     = wb_q.RegWrite;
  assign RegWriteAddr_wb = wb_q.RegWriteAddr;
  assign ALUResult_wb    = wb_q.ALUResult;
  assign misalign_err    = misalign_q;
  assign bus_err         = bus_err_q;
endmodule

// File: tb/tb_cpu_module_mem_stage.sv
// Bench for the MEM stage: instruction-level model plus directed literal cases.
module tb_cpu_module_mem_stage;
  localparam logic [7:0] T = 8'd4;

  logic        clk, rst;
  logic        MemtoReg_mem, RegWrite_mem, MemWrite_mem, MemRead_mem;
  logic [31:0] ALUResult_mem, MemWriteData_mem;
  logic [4:0]  RegWriteAddr_mem;
  logic        stall_mem, MemtoReg_wb, RegWrite_wb, misalign_err, bus_err;
  logic [4:0]  RegWriteAddr_wb;
  logic [31:0] ALUResult_wb, MemReadData_wb;

  cpu_module_mem_stage_if dif();

  cpu_module_mem_stage #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .MemtoReg_mem(MemtoReg_mem), .RegWrite_mem(RegWrite_mem),
    .MemWrite_mem(MemWrite_mem), .MemRead_mem(MemRead_mem),
    .ALUResult_mem(ALUResult_mem), .RegWriteAddr_mem(RegWriteAddr_mem),
    .MemWriteData_mem(MemWriteData_mem), .dmem(dif),
    .stall_mem(stall_mem), .MemtoReg_wb(MemtoReg_wb), .RegWrite_wb(RegWrite_wb),
    .RegWriteAddr_wb(RegWriteAddr_wb), .ALUResult_wb(ALUResult_wb),
    .MemReadData_wb(MemReadData_wb), .misalign_err(misalign_err), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  bit chk_en = 1'b0;

  // Model expectations: combinational for the current cycle, registered for WB.
  logic        e_req, e_we, e_stall, e_mtr, e_rw, e_mis, e_bus;
  logic [31:0] e_addr, e_wd, e_alu, e_rd;
  logic [4:0]  e_rad;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    e_req = 0; e_we = 0; e_stall = 0; e_mtr = 0; e_rw = 0; e_mis = 0; e_bus = 0;
    e_addr = 0; e_wd = 0; e_alu = 0; e_rd = 0; e_rad = 0;
  endtask

  always @(negedge clk) if (chk_en) begin
    chk("dmem_req",        32'(dif.dmem_req),   32'(e_req));
    chk("dmem_we",         32'(dif.dmem_we),    32'(e_we));
    chk("dmem_addr",       dif.dmem_addr,       e_addr);
    chk("dmem_wdata",      dif.dmem_wdata,      e_wd);
    chk("stall_mem",       32'(stall_mem),      32'(e_stall));
    chk("MemtoReg_wb",     32'(MemtoReg_wb),    32'(e_mtr));
    chk("RegWrite_wb",     32'(RegWrite_wb),    32'(e_rw));
    chk("RegWriteAddr_wb", 32'(RegWriteAddr_wb), 32'(e_rad));
    chk("ALUResult_wb",    ALUResult_wb,        e_alu);
    chk("MemReadData_wb",  MemReadData_wb,      e_rd);
    chk("misalign_err",    32'(misalign_err),   32'(e_mis));
    chk("bus_err",         32'(bus_err),        32'(e_bus));
  end

  // One instruction, held for as many cycles as the instruction-level rules
  // say it occupies MEM. ack_at is the request cycle (1-based) the memory
  // acks on; anything outside 1..T+1 means the access times out.
  task automatic run_instr(input bit mr, input bit mw, input bit rw, input bit mtr,
                           input logic [4:0] rad, input logic [31:0] alu,
                           input logic [31:0] wd, input int ack_at,
                           input logic [31:0] rd_ack, output int sc);
    bit go, memop, aligned;
    int total, outcome;  // 0 ok, 1 misaligned, 2 timeout
    memop   = mr | mw;
    aligned = (alu[1:0] == 2'b00);
    go      = memop && aligned;
    if (!memop)                               begin total = 1;          outcome = 0; end
    else if (!aligned)                        begin total = 1;          outcome = 1; end
    else if (ack_at >= 1 && ack_at <= int'(T) + 1) begin total = ack_at; outcome = 0; end
    else                                      begin total = int'(T) + 1; outcome = 2; end
    sc = 0;
    for (int j = 1; j <= total; j++) begin
      MemRead_mem = mr; MemWrite_mem = mw; RegWrite_mem = rw; MemtoReg_mem = mtr;
      RegWriteAddr_mem = rad; ALUResult_mem = alu; MemWriteData_mem = wd;
      dif.dmem_ack   = go ? (j == ack_at) : 1'($urandom_range(0, 1));
      dif.dmem_rdata = (go && j == ack_at) ? rd_ack : $urandom;
      e_req   = go;
      e_stall = go && (j < total);
      e_we    = go & mw;
      e_addr  = go ? alu : 32'h0;
      e_wd    = go ? wd  : 32'h0;
      @(negedge clk);
      if (stall_mem) sc++;
      @(posedge clk); #1;
      if (j < total) begin
        e_mtr = 0; e_rw = 0; e_mis = 0; e_bus = 0;
      end else begin
        e_mtr = mtr; e_rad = rad; e_alu = alu;
        e_rw  = rw && (outcome == 0);
        e_mis = (outcome == 1);
        e_bus = (outcome == 2);
        if (outcome == 0 && mr && !mw) e_rd = dif.dmem_rdata;
      end
    end
  endtask

  initial begin
    int sc;
    rst = 1'b0;
    MemRead_mem = 1; MemWrite_mem = 0; RegWrite_mem = 1; MemtoReg_mem = 1;
    RegWriteAddr_mem = 5'd3; ALUResult_mem = 32'h40; MemWriteData_mem = 0;
    dif.dmem_ack = 0; dif.dmem_rdata = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dmem_req",  32'(dif.dmem_req), 32'h0);
    chk("rst_stall",     32'(stall_mem),    32'h0);
    chk("rst_RegWrite",  32'(RegWrite_wb),  32'h0);
    chk("rst_ALUResult", ALUResult_wb,      32'h0);
    chk("rst_errs",      32'({misalign_err, bus_err}), 32'h0);
    rst = 1'b1;
    chk_en = 1'b1;

    run_instr(0, 0, 1, 0, 5'd7, 32'h1234, 32'h0, 0, 32'h0, sc);
    chk("nop_alu",   ALUResult_wb,      32'h1234);
    chk("nop_rw",    32'(RegWrite_wb),  32'h1);
    chk("nop_rad",   32'(RegWriteAddr_wb), 32'd7);
    chk("nop_stall", 32'(sc),           32'd0);

    run_instr(1, 0, 1, 1, 5'd9, 32'h40, 32'h0, 1, 32'hDEADBEEF, sc);
    chk("zw_rdata", MemReadData_wb, 32'hDEADBEEF);
    chk("zw_stall", 32'(sc),        32'd0);

    run_instr(0, 1, 0, 0, 5'd0, 32'h80, 32'h55, 4, 32'h0, sc);
    chk("st3_stall", 32'(sc), 32'd3);

    run_instr(1, 0, 1, 1, 5'd4, 32'h41, 32'h0, 1, 32'h0, sc);
    chk("mis_err", 32'(misalign_err), 32'h1);
    chk("mis_rw",  32'(RegWrite_wb),  32'h0);

    run_instr(1, 0, 1, 1, 5'd5, 32'h44, 32'h0, 0, 32'h0, sc);
    chk("tmo_stall", 32'(sc),          32'd4);
    chk("tmo_bus",   32'(bus_err),     32'h1);
    chk("tmo_rw",    32'(RegWrite_wb), 32'h0);

    run_instr(1, 0, 1, 1, 5'd6, 32'h48, 32'h0, 5, 32'hCAFEF00D, sc);
    chk("late_stall", 32'(sc),          32'd4);
    chk("late_bus",   32'(bus_err),     32'h0);
    chk("late_rw",    32'(RegWrite_wb), 32'h1);
    chk("late_rdata", MemReadData_wb,   32'hCAFEF00D);

    repeat (300) begin
      int k;
      logic [31:0] a;
      k = $urandom_range(0, 3);
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      run_instr(k == 1 || k == 3, k >= 2, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 5'($urandom), a, $urandom,
                $urandom_range(0, 6), $urandom, sc);
    end

    // Reset during the second wait cycle of an unacknowledged store.
    chk_en = 1'b0;
    MemRead_mem = 0; MemWrite_mem = 1; RegWrite_mem = 1; MemtoReg_mem = 1;
    ALUResult_mem = 32'h100; MemWriteData_mem = 32'hA5A5; RegWriteAddr_mem = 5'd2;
    dif.dmem_ack = 0;
    repeat (2) begin @(posedge clk); #1; end
    chk("pre_rst_stall", 32'(stall_mem), 32'h1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_req",   32'(dif.dmem_req), 32'h0);
    chk("mid_rst_stall", 32'(stall_mem),    32'h0);
    chk("mid_rst_wb",    32'({MemtoReg_wb, RegWrite_wb, RegWriteAddr_wb}), 32'h0);
    chk("mid_rst_alu",   ALUResult_wb,      32'h0);
    chk("mid_rst_rd",    MemReadData_wb,    32'h0);
    MemWrite_mem = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    chk_en = 1'b1;
    run_instr(0, 0, 1, 0, 5'd1, 32'h10, 32'h0, 0, 32'h0, sc);
    run_instr(1, 0, 1, 1, 5'd8, 32'h20, 32'h0, 1, 32'h12345678, sc);
    chk("post_rst_rdata", MemReadData_wb, 32'h12345678);
    chk_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
